// File: rtl/exe_stage.sv
// Execute stage: operand forwarding, Val2 generation, ALU, NZCV status register,
// branch target computation and the EX/MEM pipeline register.
module exe_stage #(
    parameter bit FWD_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_en_in,
    input  logic        mem_r_en_in,
    input  logic        mem_w_en_in,
    input  logic        b_in,
    input  logic        s_in,
    input  logic        imm_in,
    input  logic [3:0]  exe_cmd_in,
    input  logic [31:0] pc_in,
    input  logic [31:0] val_rn_in,
    input  logic [31:0] val_rm_in,
    input  logic [11:0] shift_operand_in,
    input  logic [23:0] signed_imm_24_in,
    input  logic [3:0]  dest_in,
    input  logic [3:0]  src1_in,
    input  logic [3:0]  src2_in,
    input  logic        mem_wb_en,
    input  logic        wb_wb_en,
    input  logic [3:0]  mem_dest,
    input  logic [3:0]  wb_dest,
    input  logic [31:0] mem_alu_res,
    input  logic [31:0] wb_value,
    output logic        branch_taken,
    output logic [31:0] branch_addr,
    output logic [3:0]  status,
    output logic        wb_en,
    output logic        mem_r_en,
    output logic        mem_w_en,
    output logic [31:0] alu_res,
    output logic [31:0] st_val,
    output logic [3:0]  dest
);

    localparam int unsigned DW = 32;

    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_MVN = 4'b1001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;

    logic [DW-1:0]   op_a;
    logic [DW-1:0]   op_m;
    logic [DW-1:0]   val2;
    logic [DW-1:0]   imm8;
    logic [2*DW-1:0] imm_rot;
    logic [2*DW-1:0] reg_rot;
    logic [4:0]      imm_amt;
    logic [4:0]      sh_amt;
    logic [DW:0]     sum;
    logic [DW-1:0]   res;
    logic            arith;
    logic            is_sub;
    logic            cin;
    logic            c_nxt;
    logic            v_nxt;

    // Operand forwarding; MEM stage wins over WB stage
    always_comb begin
        op_a = val_rn_in;
        op_m = val_rm_in;
        if (FWD_EN) begin
            if (mem_wb_en && (mem_dest == src1_in))
                op_a = mem_alu_res;
            else if (wb_wb_en && (wb_dest == src1_in))
                op_a = wb_value;
            if (mem_wb_en && (mem_dest == src2_in))
                op_m = mem_alu_res;
            else if (wb_wb_en && (wb_dest == src2_in))
                op_m = wb_value;
        end
    end

    // Val2: address offset, rotated 8-bit immediate, or immediate-shifted register
    always_comb begin
        imm8    = {24'b0, shift_operand_in[7:0]};
        imm_amt = {shift_operand_in[11:8], 1'b0};
        imm_rot = {imm8, imm8} >> imm_amt;
        sh_amt  = shift_operand_in[11:7];
        reg_rot = {op_m, op_m} >> sh_amt;
        val2    = op_m;
        if (mem_r_en_in || mem_w_en_in) begin
            val2 = DW'(shift_operand_in);
        end else if (imm_in) begin
            val2 = imm_rot[DW-1:0];
        end else begin
            unique case (shift_operand_in[6:5])
                2'b00:   val2 = op_m << sh_amt;
                2'b01:   val2 = op_m >> sh_amt;
                2'b10:   val2 = DW'($signed(op_m) >>> sh_amt);
                default: val2 = reg_rot[DW-1:0];
            endcase
        end
    end

    // ALU; subtraction is a + ~b + carry so C reads as "no borrow"
    always_comb begin
        cin    = status[1];
        sum    = '0;
        res    = '0;
        arith  = 1'b0;
        is_sub = 1'b0;
        unique case (exe_cmd_in)
            CMD_MOV: res = val2;
            CMD_MVN: res = ~val2;
            CMD_ADD: begin
                sum   = {1'b0, op_a} + {1'b0, val2};
                arith = 1'b1;
            end
            CMD_ADC: begin
                sum   = {1'b0, op_a} + {1'b0, val2} + (DW+1)'(cin);
                arith = 1'b1;
            end
            CMD_SUB: begin
                sum    = {1'b0, op_a} + {1'b0, ~val2} + (DW+1)'(1'b1);
                arith  = 1'b1;
                is_sub = 1'b1;
            end
            CMD_SBC: begin
                sum    = {1'b0, op_a} + {1'b0, ~val2} + (DW+1)'(cin);
                arith  = 1'b1;
                is_sub = 1'b1;
            end
            CMD_AND: res = op_a & val2;
            CMD_ORR: res = op_a | val2;
            CMD_EOR: res = op_a ^ val2;
            default: res = '0;
        endcase
        if (arith)
            res = sum[DW-1:0];
        c_nxt = status[1];
        v_nxt = status[0];
        if (arith) begin
            c_nxt = sum[DW];
            if (is_sub)
                v_nxt = (op_a[DW-1] != val2[DW-1]) && (res[DW-1] != op_a[DW-1]);
            else
                v_nxt = (op_a[DW-1] == val2[DW-1]) && (res[DW-1] != op_a[DW-1]);
        end
    end

    assign branch_taken = b_in;
    assign branch_addr  = pc_in + {{6{signed_imm_24_in[23]}}, signed_imm_24_in, 2'b00};

    // Status register loads only for S-instructions
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            status <= 4'b0;
        else if (s_in)
            status <= {res[DW-1], (res == '0), c_nxt, v_nxt};
    end

    // EX/MEM pipeline register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_en    <= 1'b0;
            mem_r_en <= 1'b0;
            mem_w_en <= 1'b0;
            alu_res  <= '0;
            st_val   <= '0;
            dest     <= 4'b0;
        end else begin
            wb_en    <= wb_en_in;
            mem_r_en <= mem_r_en_in;
            mem_w_en <= mem_w_en_in;
            alu_res  <= res;
            st_val   <= op_m;
            dest     <= dest_in;
        end
    end

endmodule

// File: tb/tb_exe_stage.sv
// Bench for exe_stage: directed cases plus randomized traffic against an arithmetic
// reference model, run on a forwarding and a non-forwarding instance side by side.
module tb_exe_stage;

    localparam longint TWO32 = 64'sh1_0000_0000;
    localparam longint MAXS  = 64'sh7FFF_FFFF;
    localparam longint MINS  = -64'sh8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, imm_in;
    logic [3:0]  exe_cmd_in;
    logic [31:0] pc_in, val_rn_in, val_rm_in;
    logic [11:0] shift_operand_in;
    logic [23:0] signed_imm_24_in;
    logic [3:0]  dest_in, src1_in, src2_in;
    logic        mem_wb_en, wb_wb_en;
    logic [3:0]  mem_dest, wb_dest;
    logic [31:0] mem_alu_res, wb_value;

    logic        f_taken, n_taken;
    logic [31:0] f_baddr, n_baddr;
    logic [3:0]  f_status, n_status;
    logic        f_wb_en, f_mem_r_en, f_mem_w_en, n_wb_en, n_mem_r_en, n_mem_w_en;
    logic [31:0] f_alu_res, f_st_val, n_alu_res, n_st_val;
    logic [3:0]  f_dest, n_dest;

    int errors = 0;
    int checks = 0;

    logic [3:0]  fl_f, fl_n;
    logic [31:0] exp_res_f, exp_st_f, exp_res_n, exp_st_n;
    logic [6:0]  exp_ctrl;

    always #5 clk = ~clk;

    exe_stage #(.FWD_EN(1'b1)) u_fwd (
        .clk(clk), .rst(rst),
        .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
        .b_in(b_in), .s_in(s_in), .imm_in(imm_in), .exe_cmd_in(exe_cmd_in),
        .pc_in(pc_in), .val_rn_in(val_rn_in), .val_rm_in(val_rm_in),
        .shift_operand_in(shift_operand_in), .signed_imm_24_in(signed_imm_24_in),
        .dest_in(dest_in), .src1_in(src1_in), .src2_in(src2_in),
        .mem_wb_en(mem_wb_en), .wb_wb_en(wb_wb_en), .mem_dest(mem_dest), .wb_dest(wb_dest),
        .mem_alu_res(mem_alu_res), .wb_value(wb_value),
        .branch_taken(f_taken), .branch_addr(f_baddr), .status(f_status),
        .wb_en(f_wb_en), .mem_r_en(f_mem_r_en), .mem_w_en(f_mem_w_en),
        .alu_res(f_alu_res), .st_val(f_st_val), .dest(f_dest)
    );

    exe_stage #(.FWD_EN(1'b0)) u_nofwd (
        .clk(clk), .rst(rst),
        .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
        .b_in(b_in), .s_in(s_in), .imm_in(imm_in), .exe_cmd_in(exe_cmd_in),
        .pc_in(pc_in), .val_rn_in(val_rn_in), .val_rm_in(val_rm_in),
        .shift_operand_in(shift_operand_in), .signed_imm_24_in(signed_imm_24_in),
        .dest_in(dest_in), .src1_in(src1_in), .src2_in(src2_in),
        .mem_wb_en(mem_wb_en), .wb_wb_en(wb_wb_en), .mem_dest(mem_dest), .wb_dest(wb_dest),
        .mem_alu_res(mem_alu_res), .wb_value(wb_value),
        .branch_taken(n_taken), .branch_addr(n_baddr), .status(n_status),
        .wb_en(n_wb_en), .mem_r_en(n_mem_r_en), .mem_w_en(n_mem_w_en),
        .alu_res(n_alu_res), .st_val(n_st_val), .dest(n_dest)
    );

    // Reference model: ALU and flags from wide signed/unsigned integer arithmetic
    function automatic void model(input bit fwd, input logic [3:0] fl,
                                  output logic [31:0] res, output logic [3:0] nfl,
                                  output logic [31:0] m);
        logic [31:0] a, v2;
        longint ua, ub, sa, sb, r, br;
        logic c, v;
        int n;
        a = (fwd && mem_wb_en && mem_dest == src1_in) ? mem_alu_res :
            (fwd && wb_wb_en && wb_dest == src1_in) ? wb_value : val_rn_in;
        m = (fwd && mem_wb_en && mem_dest == src2_in) ? mem_alu_res :
            (fwd && wb_wb_en && wb_dest == src2_in) ? wb_value : val_rm_in;
        if (mem_r_en_in || mem_w_en_in) begin
            v2 = {20'b0, shift_operand_in};
        end else if (imm_in) begin
            v2 = {24'b0, shift_operand_in[7:0]};
            n = 2 * int'(shift_operand_in[11:8]);
            for (int i = 0; i < n; i++) v2 = {v2[0], v2[31:1]};
        end else begin
            v2 = m;
            n = int'(shift_operand_in[11:7]);
            for (int i = 0; i < n; i++) begin
                case (shift_operand_in[6:5])
                    2'b00:   v2 = {v2[30:0], 1'b0};
                    2'b01:   v2 = {1'b0, v2[31:1]};
                    2'b10:   v2 = {v2[31], v2[31:1]};
                    default: v2 = {v2[0], v2[31:1]};
                endcase
            end
        end
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, v2});
        sa = longint'($signed(a));
        sb = longint'($signed(v2));
        c = fl[1];
        v = fl[0];
        case (exe_cmd_in)
            4'b0001: res = v2;
            4'b1001: res = ~v2;
            4'b0010, 4'b0011: begin
                br = (exe_cmd_in == 4'b0011) ? longint'(fl[1]) : 64'sd0;
                r = ua + ub + br;
                res = r[31:0];
                c = (r >= TWO32);
                r = sa + sb + br;
                v = (r > MAXS) || (r < MINS);
            end
            4'b0100, 4'b0101: begin
                br = (exe_cmd_in == 4'b0101) ? longint'(!fl[1]) : 64'sd0;
                r = ua - ub - br;
                res = r[31:0];
                c = (ua >= ub + br);
                r = sa - sb - br;
                v = (r > MAXS) || (r < MINS);
            end
            4'b0110: res = a & v2;
            4'b0111: res = a | v2;
            4'b1000: res = a ^ v2;
            default: res = 32'b0;
        endcase
        nfl = s_in ? {res[31], (res == 32'b0), c, v} : fl;
    endfunction

    task automatic clear_inputs();
        {wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, imm_in} = 6'b0;
        exe_cmd_in = 4'b0; pc_in = 32'b0; val_rn_in = 32'b0; val_rm_in = 32'b0;
        shift_operand_in = 12'b0; signed_imm_24_in = 24'b0;
        dest_in = 4'b0; src1_in = 4'b0; src2_in = 4'b0;
        mem_wb_en = 1'b0; wb_wb_en = 1'b0; mem_dest = 4'b0; wb_dest = 4'b0;
        mem_alu_res = 32'b0; wb_value = 32'b0;
    endtask

    // Predict both instances, clock once, then advance the model flags
    task automatic apply_and_clock();
        logic [3:0] nf_f, nf_n;
        model(1'b1, fl_f, exp_res_f, nf_f, exp_st_f);
        model(1'b0, fl_n, exp_res_n, nf_n, exp_st_n);
        exp_ctrl = {wb_en_in, mem_r_en_in, mem_w_en_in, dest_in};
        @(posedge clk);
        #1;
        fl_f = nf_f;
        fl_n = nf_n;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        fl_f = 4'b0;
        fl_n = 4'b0;
        #12;
        checks++;
        if ({f_status, f_alu_res, f_wb_en, f_st_val, f_dest} !== 73'b0) begin
            errors++;
            $display("FAIL reset_state: got st=%h res=%h wb=%b sv=%h d=%h expected all zero",
                     f_status, f_alu_res, f_wb_en, f_st_val, f_dest);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_add_overflow();
        clear_inputs();
        exe_cmd_in = 4'b0010; s_in = 1'b1; imm_in = 1'b1;
        shift_operand_in = 12'h001; val_rn_in = 32'h7FFF_FFFF;
        apply_and_clock();
        checks++;
        if (f_alu_res !== 32'h8000_0000 || f_status !== 4'b1001) begin
            errors++;
            $display("FAIL add_overflow: got res=%h st=%b expected res=80000000 st=1001",
                     f_alu_res, f_status);
        end
    endtask

    task automatic test_sub_adc();
        clear_inputs();
        exe_cmd_in = 4'b0100; s_in = 1'b1; imm_in = 1'b1;
        shift_operand_in = 12'h005; val_rn_in = 32'd5;
        apply_and_clock();
        checks++;
        if (f_alu_res !== 32'h0 || f_status !== 4'b0110) begin
            errors++;
            $display("FAIL sub_zero: got res=%h st=%b expected res=0 st=0110", f_alu_res, f_status);
        end
        exe_cmd_in = 4'b0011; s_in = 1'b0;
        shift_operand_in = 12'h001; val_rn_in = 32'd1;
        apply_and_clock();
        checks++;
        if (f_alu_res !== 32'd3 || f_status !== 4'b0110) begin
            errors++;
            $display("FAIL adc_carry_in: got res=%h st=%b expected res=3 st=0110", f_alu_res, f_status);
        end
    endtask

    task automatic test_val2();
        clear_inputs();
        exe_cmd_in = 4'b0001; imm_in = 1'b1; shift_operand_in = 12'h2FF;
        apply_and_clock();
        checks++;
        if (f_alu_res !== 32'hF000_000F) begin
            errors++;
            $display("FAIL imm_rotate: got %h expected f000000f", f_alu_res);
        end
        imm_in = 1'b0; val_rm_in = 32'h8000_0000;
        shift_operand_in = {5'd4, 2'b10, 5'b0};
        apply_and_clock();
        checks++;
        if (f_alu_res !== 32'hF800_0000) begin
            errors++;
            $display("FAIL reg_asr: got %h expected f8000000", f_alu_res);
        end
        mem_r_en_in = 1'b1; exe_cmd_in = 4'b0010; val_rn_in = 32'h1000;
        shift_operand_in = 12'hFFC;
        apply_and_clock();
        checks++;
        if (f_alu_res !== 32'h1FFC || f_mem_r_en !== 1'b1) begin
            errors++;
            $display("FAIL ldst_offset: got res=%h mr=%b expected res=00001ffc mr=1",
                     f_alu_res, f_mem_r_en);
        end
    endtask

    task automatic test_forwarding();
        clear_inputs();
        exe_cmd_in = 4'b0010; imm_in = 1'b1; shift_operand_in = 12'h000;
        src1_in = 4'd3; src2_in = 4'd3; val_rn_in = 32'h33; val_rm_in = 32'h44;
        mem_wb_en = 1'b1; mem_dest = 4'd3; mem_alu_res = 32'h11;
        wb_wb_en = 1'b1; wb_dest = 4'd3; wb_value = 32'h22;
        apply_and_clock();
        checks++;
        if (f_alu_res !== 32'h11 || f_st_val !== 32'h11) begin
            errors++;
            $display("FAIL fwd_mem_priority: got res=%h sv=%h expected 11/11", f_alu_res, f_st_val);
        end
        checks++;
        if (n_alu_res !== 32'h33 || n_st_val !== 32'h44) begin
            errors++;
            $display("FAIL fwd_disabled: got res=%h sv=%h expected 33/44", n_alu_res, n_st_val);
        end
        mem_dest = 4'd4;
        apply_and_clock();
        checks++;
        if (f_alu_res !== 32'h22 || f_st_val !== 32'h22) begin
            errors++;
            $display("FAIL fwd_wb: got res=%h sv=%h expected 22/22", f_alu_res, f_st_val);
        end
    endtask

    task automatic test_branch();
        clear_inputs();
        b_in = 1'b1; pc_in = 32'h100; signed_imm_24_in = 24'hFFFFFE;
        #1;
        checks++;
        if (f_baddr !== 32'hF8 || f_taken !== 1'b1) begin
            errors++;
            $display("FAIL branch_back: got addr=%h taken=%b expected 000000f8/1", f_baddr, f_taken);
        end
        signed_imm_24_in = 24'h7FFFFF; pc_in = 32'hFFFF_FFF0;
        #1;
        checks++;
        if (f_baddr !== 32'h01FF_FFEC) begin
            errors++;
            $display("FAIL branch_wrap: got %h expected 01ffffec", f_baddr);
        end
        b_in = 1'b0;
        #1;
        checks++;
        if (f_taken !== 1'b0) begin
            errors++;
            $display("FAIL branch_not_taken: got %b expected 0", f_taken);
        end
    endtask

    task automatic test_mid_reset();
        clear_inputs();
        exe_cmd_in = 4'b0100; s_in = 1'b1; imm_in = 1'b1; wb_en_in = 1'b1;
        shift_operand_in = 12'h009; val_rn_in = 32'd9;
        apply_and_clock();
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (f_status !== 4'b0 || f_alu_res !== 32'b0 || f_wb_en !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got st=%b res=%h wb=%b expected 0/0/0",
                     f_status, f_alu_res, f_wb_en);
        end
        fl_f = 4'b0;
        fl_n = 4'b0;
        #1;
        rst = 1'b0;
        exe_cmd_in = 4'b0001; s_in = 1'b1; shift_operand_in = 12'h000;
        apply_and_clock();
        checks++;
        if (f_status !== 4'b0100 || f_wb_en !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_load: got st=%b wb=%b expected 0100/1", f_status, f_wb_en);
        end
    endtask

    task automatic test_random();
        logic [31:0] exp_b;
        int off;
        for (int it = 0; it < 300; it++) begin
            {wb_en_in, b_in, s_in, imm_in} = 4'($urandom);
            mem_r_en_in = ($urandom_range(0, 7) == 0);
            mem_w_en_in = !mem_r_en_in && ($urandom_range(0, 7) == 0);
            exe_cmd_in = 4'($urandom);
            pc_in = $urandom;
            val_rn_in = ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFFF : $urandom;
            val_rm_in = $urandom;
            shift_operand_in = 12'($urandom);
            signed_imm_24_in = 24'($urandom);
            dest_in = 4'($urandom);
            src1_in = 4'($urandom_range(0, 3));
            src2_in = 4'($urandom_range(0, 3));
            mem_wb_en = 1'($urandom);
            wb_wb_en = 1'($urandom);
            mem_dest = 4'($urandom_range(0, 3));
            wb_dest = 4'($urandom_range(0, 3));
            mem_alu_res = $urandom;
            wb_value = $urandom;
            #1;
            off = int'($signed(signed_imm_24_in));
            exp_b = pc_in + 32'(off * 4);
            checks++;
            if (f_baddr !== exp_b || n_baddr !== exp_b || f_taken !== b_in) begin
                errors++;
                $display("FAIL rand_branch it=%0d: got %h/%h/%b expected %h/%b",
                         it, f_baddr, n_baddr, f_taken, exp_b, b_in);
            end
            apply_and_clock();
            checks++;
            if ({f_alu_res, f_st_val, f_status, f_wb_en, f_mem_r_en, f_mem_w_en, f_dest} !==
                {exp_res_f, exp_st_f, fl_f, exp_ctrl}) begin
                errors++;
                $display("FAIL rand_fwd it=%0d: got res=%h sv=%h st=%b expected res=%h sv=%h st=%b",
                         it, f_alu_res, f_st_val, f_status, exp_res_f, exp_st_f, fl_f);
            end
            checks++;
            if ({n_alu_res, n_st_val, n_status, n_wb_en, n_mem_r_en, n_mem_w_en, n_dest} !==
                {exp_res_n, exp_st_n, fl_n, exp_ctrl}) begin
                errors++;
                $display("FAIL rand_nofwd it=%0d: got res=%h sv=%h st=%b expected res=%h sv=%h st=%b",
                         it, n_alu_res, n_st_val, n_status, exp_res_n, exp_st_n, fl_n);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add_overflow();
        test_sub_adc();
        test_val2();
        test_forwarding();
        test_branch();
        test_mid_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
